ace_5state_line_tracker: RTL and testbench
==========================================

# ace_5state_line_tracker

A parametrised successor to the 3-state ACE line FSM. It tracks coherence state for `NUM_LINES` cache lines using the five ACE states: Invalid, UniqueClean, UniqueDirty, SharedClean and SharedDirty. It serves local read/write/evict requests and AC-channel snoops, and returns CRRESP over a valid/ready CR handshake. It sits between the master's cache-control logic and the interconnect snoop port, and drives the same memory/cache action strobes as the 3-state FSM.

## Interface
- `NUM_LINES`, 4: number of tracked lines; must be a power of two, ≥2 (elaboration error otherwise).
- `IDX_W`, `$clog2(NUM_LINES)`: line-index width; derived, not overridden.
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input 1: local request valid.
- `req_ready` output 1: local request accepted when both are high.
- `req_op` input 2: 0 READ, 1 WRITE, 2 EVICT, 3 reserved (accepted as no-op).
- `req_idx` input IDX_W: line index of the local request.
- `acvalid` input 1: snoop valid.
- `acready` output 1: snoop accepted when both are high.
- `acsnoop` input 4: ACE snoop opcode.
- `ac_idx` input IDX_W: line index of the snoop.
- `crvalid` output 1: snoop response valid.
- `crready` input 1: response accepted.
- `crresp` output 5: bit 0 DataTransfer, bit 1 Error, bit 2 PassDirty, bit 3 IsShared, bit 4 WasUnique.
- `read_main_mem`, `read_cache`, `write_main_mem`, `write_cache` output 1 each: single-cycle action strobes.
- `upgrade` output 1: single-cycle strobe on a write to a shared line.
- `state_dbg` output 3*NUM_LINES: packed per-line state; line i is at [3i+2:3i].

## Operation
- Line-state encoding: INV=0, UC=1, UD=2, SC=3, SD=4. All lines are INV at reset.
- Controller FSM has two states: IDLE and RESP.
- In IDLE:
  - `acready=1`.
  - `req_ready = !acvalid`, so a snoop has priority over a same-cycle local request.
- In RESP: `acready=0` and `req_ready=0`.
- Local READ:
  - INV → UC, pulse `read_main_mem`.
  - Any valid state is unchanged, pulse `read_cache`.
- Local WRITE:
  - INV → UD, pulse `read_main_mem` and `write_cache`.
  - UC/UD → UD, pulse `write_cache`.
  - SC/SD → UD, pulse `write_cache` and `upgrade`.
- Local EVICT:
  - UD/SD → INV, pulse `write_main_mem`.
  - UC/SC → INV, no strobe.
  - INV: no-op.
- Snoop response bits, common to all opcodes below:
  - V means the line is not INV.
  - U means the line is UC or UD.
  - D means the line is UD or SD.
  - WasUnique is always U, evaluated on the pre-snoop state.
- Snoop ReadOnce (0000): state unchanged; DataTransfer=V, IsShared=V.
- Snoop ReadShared (0001): UC→SC, UD→SD, shared states unchanged; DataTransfer=V, IsShared=V.
- Snoop ReadUnique (0111): line → INV; DataTransfer=V, PassDirty=D.
- Snoop CleanShared (1000): UD→UC, SD→SC, pulse `write_main_mem` if D; IsShared=V.
- Snoop CleanInvalid (1001): line → INV, pulse `write_main_mem` if D.
- Snoop MakeInvalid (1101): line → INV, dirty data dropped, no strobe.
- Any other opcode: state unchanged; `crresp=5'b00010` (Error only).

## Timing
- Snoop handshake at edge T:
  - The line state and registered `crresp` update at T.
  - `crvalid=1` from T.
  - FSM enters RESP.
- `crvalid` and `crresp` hold stable until `crready=1` at an edge. The FSM then returns to IDLE, leaving one bubble cycle before the next snoop can be accepted.
- Local handshake at edge T:
  - The line state updates at T.
  - Strobes are registered and high for exactly the cycle following T.
  - Back-to-back requests are allowed every cycle. A second request to the same index sees the updated state.
- Snoop strobe: `write_main_mem` is high for the cycle following acceptance.
- Reset values:
  - All lines INV.
  - FSM IDLE.
  - `crvalid`, `crresp` and all strobes 0.
  - `acready` and `req_ready` forced 0 while `rst` is high.
- Reset mid-RESP: the response is abandoned, and `crvalid=0` on the cycle after reset is sampled.
- Reserved `req_op`: accepted, with no state change and no strobe.

## Structure
- Package `ace_pkg` holds:
  - the `line_state_t` enum (3 bits);
  - the snoop opcode localparams;
  - the CRRESP bit-index localparams;
  - the `req_op` encodings.
- Sub-module `ace_line_next`: combinational function from (state, opcode/op, is_snoop) to (next state, crresp, strobes).
- The top level holds the state array, the IDLE/RESP FSM, the handshake logic and the output registers.

## Test plan
- Reset, then local READ idx 2: `read_main_mem` pulses once and `state_dbg[8:6]=1` (UC). A second READ to idx 2 pulses only `read_cache`.
- WRITE idx 1 from INV: `read_main_mem` and `write_cache` pulse, state UD. ReadShared snoop to idx 1 gives `crresp=5'b11001` and state SD. Local WRITE to idx 1 then pulses `upgrade`, state UD.
- UD line idx 3 with ReadUnique snoop, `crready` held low for 3 cycles: `crvalid` and `crresp=5'b10101` stay stable for 3 cycles; `acready=0` throughout; state INV.
- Simultaneous `acvalid` (CleanShared, idx 0, UD) and `req_valid`: the snoop wins and `req_ready=0`. State becomes UC and `write_main_mem` pulses. The request is accepted after `crready`.
- Unsupported `acsnoop=4'b0011` on a UC line: `crresp=5'b00010`, state unchanged.
- Assert `rst` while `crvalid=1`: the next cycle shows `crvalid=0` and all `state_dbg` zero.

Source files
------------

// File: rtl/ace_pkg.sv
// Shared types and encodings for the 5-state ACE line tracker.
package ace_pkg;

   typedef enum logic [2:0] {
      LS_INV = 3'd0,
      LS_UC  = 3'd1,
      LS_UD  = 3'd2,
      LS_SC  = 3'd3,
      LS_SD  = 3'd4
   } line_state_t;

   localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
   localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
   localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
   localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
   localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
   localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

   localparam int unsigned CR_W  = 5;
   localparam int unsigned CR_DT = 0;
   localparam int unsigned CR_ERR = 1;
   localparam int unsigned CR_PD = 2;
   localparam int unsigned CR_IS = 3;
   localparam int unsigned CR_WU = 4;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_EVICT = 2'd2;

   typedef struct packed {
      logic read_main_mem;
      logic read_cache;
      logic write_main_mem;
      logic write_cache;
      logic upgrade;
   } strobe_t;

endpackage

// File: rtl/ace_line_next.sv
// Per-line transition function: next state, snoop response and action strobes.
module ace_line_next
   import ace_pkg::*;
(
   input  line_state_t       state_i,
   input  logic [3:0]        op_i,
   input  logic              is_snoop_i,
   output line_state_t       next_c_o,
   output logic [CR_W-1:0]   crresp_c_o,
   output strobe_t           strb_c_o
);

   logic v, u, d;

   assign v = (state_i != LS_INV);
   assign u = (state_i == LS_UC) || (state_i == LS_UD);
   assign d = (state_i == LS_UD) || (state_i == LS_SD);

   always_comb begin
      next_c_o   = state_i;
      crresp_c_o = '0;
      strb_c_o   = '0;
      if (is_snoop_i) begin
         crresp_c_o[CR_WU] = u;
         case (op_i)
            SNP_READ_ONCE: begin
               crresp_c_o[CR_DT] = v;
               crresp_c_o[CR_IS] = v;
            end
            SNP_READ_SHARED: begin
               if (state_i == LS_UC) next_c_o = LS_SC;
               else if (state_i == LS_UD) next_c_o = LS_SD;
               crresp_c_o[CR_DT] = v;
               crresp_c_o[CR_IS] = v;
            end
            SNP_READ_UNIQUE: begin
               next_c_o          = LS_INV;
               crresp_c_o[CR_DT] = v;
               crresp_c_o[CR_PD] = d;
            end
            SNP_CLEAN_SHARED: begin
               if (state_i == LS_UD) next_c_o = LS_UC;
               else if (state_i == LS_SD) next_c_o = LS_SC;
               strb_c_o.write_main_mem = d;
               crresp_c_o[CR_IS]       = v;
            end
            SNP_CLEAN_INVALID: begin
               next_c_o                = LS_INV;
               strb_c_o.write_main_mem = d;
            end
            SNP_MAKE_INVALID: begin
               next_c_o = LS_INV;
            end
            default: begin
               // Unsupported snoop: report Error only, including WasUnique cleared
               crresp_c_o         = '0;
               crresp_c_o[CR_ERR] = 1'b1;
            end
         endcase
      end else begin
         case (op_i[1:0])
            OP_READ: begin
               if (!v) begin
                  next_c_o               = LS_UC;
                  strb_c_o.read_main_mem = 1'b1;
               end else begin
                  strb_c_o.read_cache = 1'b1;
               end
            end
            OP_WRITE: begin
               next_c_o               = LS_UD;
               strb_c_o.read_main_mem = !v;
               strb_c_o.write_cache   = 1'b1;
               strb_c_o.upgrade       = v && !u;
            end
            OP_EVICT: begin
               next_c_o                = LS_INV;
               strb_c_o.write_main_mem = d;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ace_5state_line_tracker.sv
// Tracks ACE coherence state for NUM_LINES lines; serves local requests and AC snoops.
module ace_5state_line_tracker
   import ace_pkg::*;
#(
   parameter  int unsigned NUM_LINES = 4,
   localparam int unsigned IDX_W     = $clog2(NUM_LINES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [IDX_W-1:0]       req_idx,
   input  logic                   acvalid,
   output logic                   acready,
   input  logic [3:0]             acsnoop,
   input  logic [IDX_W-1:0]       ac_idx,
   output logic                   crvalid,
   input  logic                   crready,
   output logic [4:0]             crresp,
   output logic                   read_main_mem,
   output logic                   read_cache,
   output logic                   write_main_mem,
   output logic                   write_cache,
   output logic                   upgrade,
   output logic [3*NUM_LINES-1:0] state_dbg
);

   if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0) begin : g_bad_num_lines
      $error("NUM_LINES must be a power of two >= 2");
   end

   typedef enum logic {CTL_IDLE, CTL_RESP} ctl_state_t;

   ctl_state_t        ctl_q, ctl_d;
   line_state_t       line_q [NUM_LINES];
   logic              crvalid_q, crvalid_d;
   logic [CR_W-1:0]   crresp_q, crresp_d;
   strobe_t           strb_q, strb_d;

   logic              snp_fire, req_fire;
   logic [IDX_W-1:0]  sel_idx;
   logic [3:0]        sel_op;
   line_state_t       nxt_state;
   logic [CR_W-1:0]   nxt_crresp;
   strobe_t           nxt_strb;

   // Snoops take priority over a same-cycle local request
   assign acready   = !rst && (ctl_q == CTL_IDLE);
   assign req_ready = acready && !acvalid;
   assign snp_fire  = acvalid && acready;
   assign req_fire  = req_valid && req_ready;
   assign sel_idx   = snp_fire ? ac_idx : req_idx;
   assign sel_op    = snp_fire ? acsnoop : {2'b00, req_op};

   ace_line_next u_line_next (
      .state_i    (line_q[sel_idx]),
      .op_i       (sel_op),
      .is_snoop_i (snp_fire),
      .next_c_o   (nxt_state),
      .crresp_c_o (nxt_crresp),
      .strb_c_o   (nxt_strb)
   );

   always_comb begin
      ctl_d     = ctl_q;
      crvalid_d = crvalid_q;
      crresp_d  = crresp_q;
      strb_d    = '0;
      case (ctl_q)
         CTL_IDLE: begin
            if (snp_fire) begin
               ctl_d     = CTL_RESP;
               crvalid_d = 1'b1;
               crresp_d  = nxt_crresp;
               strb_d    = nxt_strb;
            end else if (req_fire) begin
               strb_d = nxt_strb;
            end
         end
         CTL_RESP: begin
            if (crready) begin
               ctl_d     = CTL_IDLE;
               crvalid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctl_q     <= CTL_IDLE;
         crvalid_q <= 1'b0;
         crresp_q  <= '0;
         strb_q    <= '0;
         for (int i = 0; i < NUM_LINES; i++) line_q[i] <= LS_INV;
      end else begin
         ctl_q     <= ctl_d;
         crvalid_q <= crvalid_d;
         crresp_q  <= crresp_d;
         strb_q    <= strb_d;
         if (snp_fire || req_fire) line_q[sel_idx] <= nxt_state;
      end
   end

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_dbg
      assign state_dbg[3*g +: 3] = line_q[g];
   end

   assign crvalid        = crvalid_q;
   assign crresp         = crresp_q;
   assign read_main_mem  = strb_q.read_main_mem;
   assign read_cache     = strb_q.read_cache;
   assign write_main_mem = strb_q.write_main_mem;
   assign write_cache    = strb_q.write_cache;
   assign upgrade        = strb_q.upgrade;

endmodule

// File: tb/tb_ace_5state_line_tracker.sv
// Bench for ace_5state_line_tracker: directed scenarios then random traffic vs a line-state model.
module tb_ace_5state_line_tracker;

   localparam int unsigned NUM_LINES = 4;
   localparam int unsigned IDX_W     = 2;

   logic                   clk, rst;
   logic                   req_valid, req_ready;
   logic [1:0]             req_op;
   logic [IDX_W-1:0]       req_idx;
   logic                   acvalid, acready;
   logic [3:0]             acsnoop;
   logic [IDX_W-1:0]       ac_idx;
   logic                   crvalid, crready;
   logic [4:0]             crresp;
   logic                   read_main_mem, read_cache, write_main_mem, write_cache, upgrade;
   logic [3*NUM_LINES-1:0] state_dbg;

   ace_5state_line_tracker #(.NUM_LINES(NUM_LINES)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_idx(req_idx),
      .acvalid(acvalid), .acready(acready), .acsnoop(acsnoop), .ac_idx(ac_idx),
      .crvalid(crvalid), .crready(crready), .crresp(crresp),
      .read_main_mem(read_main_mem), .read_cache(read_cache),
      .write_main_mem(write_main_mem), .write_cache(write_cache),
      .upgrade(upgrade), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: line states as integers 0=I 1=UC 2=UD 3=SC 4=SD
   int         m_line [NUM_LINES];
   bit         m_resp;
   bit         m_crvalid;
   logic [4:0] m_crresp;
   logic [4:0] m_strb;   // {rmm, rc, wmm, wc, upg}

   function automatic bit is_valid(input int s); return s != 0; endfunction
   function automatic bit is_uniq(input int s);  return s == 1 || s == 2; endfunction
   function automatic bit is_dirty(input int s); return s == 2 || s == 4; endfunction

   function automatic logic [3*NUM_LINES-1:0] exp_dbg();
      logic [3*NUM_LINES-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_LINES; i++) r[3*i +: 3] = 3'(m_line[i]);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_LINES; i++) m_line[i] = 0;
      m_resp = 0; m_crvalid = 0; m_crresp = '0; m_strb = '0;
   endtask

   task automatic model_snoop(input logic [3:0] snp, input int idx);
      int s;
      bit v, u, d;
      s = m_line[idx];
      v = is_valid(s); u = is_uniq(s); d = is_dirty(s);
      m_crresp    = '0;
      m_crresp[4] = u;
      case (snp)
         4'b0000: begin m_crresp[0] = v; m_crresp[3] = v; end
         4'b0001: begin
            if (u) m_line[idx] = d ? 4 : 3;
            m_crresp[0] = v; m_crresp[3] = v;
         end
         4'b0111: begin m_line[idx] = 0; m_crresp[0] = v; m_crresp[2] = d; end
         4'b1000: begin
            if (d) m_line[idx] = u ? 1 : 3;
            m_strb[2] = d; m_crresp[3] = v;
         end
         4'b1001: begin m_line[idx] = 0; m_strb[2] = d; end
         4'b1101: m_line[idx] = 0;
         default: m_crresp = 5'b00010;
      endcase
   endtask

   task automatic model_local(input logic [1:0] op, input int idx);
      int s;
      s = m_line[idx];
      case (op)
         2'd0: begin
            if (s == 0) begin m_line[idx] = 1; m_strb[4] = 1; end
            else m_strb[3] = 1;
         end
         2'd1: begin
            m_strb[4] = (s == 0);
            m_strb[1] = 1;
            m_strb[0] = (s == 3 || s == 4);
            m_line[idx] = 2;
         end
         2'd2: begin m_strb[2] = is_dirty(s); m_line[idx] = 0; end
         default: ;
      endcase
   endtask

   // One clock of stimulus: checks handshake readies before the edge, registered outputs after
   task automatic cycle(input logic acv, input logic [3:0] snp, input logic [IDX_W-1:0] aidx,
                        input logic rqv, input logic [1:0] op, input logic [IDX_W-1:0] ridx,
                        input logic crr);
      acvalid = acv; acsnoop = snp; ac_idx = aidx;
      req_valid = rqv; req_op = op; req_idx = ridx; crready = crr;
      #1;
      check_eq("acready", 32'(acready), 32'(!m_resp));
      check_eq("req_ready", 32'(req_ready), 32'(!m_resp && !acv));
      m_strb = '0;
      if (m_resp) begin
         if (crr) begin m_resp = 0; m_crvalid = 0; end
      end else if (acv) begin
         model_snoop(snp, int'(aidx));
         m_resp = 1; m_crvalid = 1;
      end else if (rqv) begin
         model_local(op, int'(ridx));
      end
      @(posedge clk); #1;
      check_eq("crvalid", 32'(crvalid), 32'(m_crvalid));
      if (m_crvalid) check_eq("crresp", 32'(crresp), 32'(m_crresp));
      check_eq("strobes", 32'({read_main_mem, read_cache, write_main_mem, write_cache, upgrade}),
               32'(m_strb));
      check_eq("state_dbg", 32'(state_dbg), 32'(exp_dbg()));
   endtask

   task automatic do_reset();
      rst = 1; acvalid = 1; req_valid = 1; crready = 0;
      #1;
      check_eq("rst_acready", 32'(acready), 32'd0);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      acvalid = 0; req_valid = 0;
      check_eq("rst_crvalid", 32'(crvalid), 32'd0);
      check_eq("rst_crresp", 32'(crresp), 32'd0);
      check_eq("rst_state", 32'(state_dbg), 32'd0);
      check_eq("rst_strobes",
               32'({read_main_mem, read_cache, write_main_mem, write_cache, upgrade}), 32'd0);
      rst = 0;
      model_reset();
   endtask

   logic [3:0] snp_tab [8] = '{4'b0000, 4'b0001, 4'b0111, 4'b1000,
                               4'b1001, 4'b1101, 4'b0011, 4'b1111};

   initial begin
      rst = 0; req_valid = 0; req_op = '0; req_idx = '0;
      acvalid = 0; acsnoop = '0; ac_idx = '0; crready = 0;
      model_reset();
      do_reset();

      // Local reads: miss then hit
      cycle(0, 4'h0, 0, 1, 2'd0, 2, 0);
      check_eq("rd_miss_rmm", 32'(read_main_mem), 32'd1);
      check_eq("rd_miss_st", 32'(state_dbg[8:6]), 32'd1);
      cycle(0, 4'h0, 0, 1, 2'd0, 2, 0);
      check_eq("rd_hit_rc", 32'(read_cache), 32'd1);
      check_eq("rd_hit_rmm", 32'(read_main_mem), 32'd0);

      // Write miss, ReadShared, upgrade
      cycle(0, 4'h0, 0, 1, 2'd1, 1, 0);
      check_eq("wr_miss_rmm", 32'(read_main_mem), 32'd1);
      check_eq("wr_miss_wc", 32'(write_cache), 32'd1);
      cycle(1, 4'b0001, 1, 0, 2'd0, 0, 0);
      check_eq("rs_crresp", 32'(crresp), 32'b11001);
      check_eq("rs_st", 32'(state_dbg[5:3]), 32'd4);
      cycle(0, 4'h0, 0, 0, 2'd0, 0, 1);
      cycle(0, 4'h0, 0, 1, 2'd1, 1, 0);
      check_eq("upg", 32'(upgrade), 32'd1);
      check_eq("upg_st", 32'(state_dbg[5:3]), 32'd2);

      // ReadUnique with crready stalled; a further snoop waits
      cycle(0, 4'h0, 0, 1, 2'd1, 3, 0);
      cycle(1, 4'b0111, 3, 0, 2'd0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cycle(1, 4'b0000, 0, 0, 2'd0, 0, 0);
         check_eq("ru_hold_crresp", 32'(crresp), 32'b10101);
         check_eq("ru_hold_acready", 32'(acready), 32'd0);
      end
      cycle(0, 4'h0, 0, 0, 2'd0, 0, 1);
      check_eq("ru_st", 32'(state_dbg[11:9]), 32'd0);

      // Snoop wins over same-cycle request
      cycle(0, 4'h0, 0, 1, 2'd1, 0, 0);
      cycle(1, 4'b1000, 0, 1, 2'd0, 2, 0);
      check_eq("cs_wmm", 32'(write_main_mem), 32'd1);
      check_eq("cs_st", 32'(state_dbg[2:0]), 32'd1);
      cycle(0, 4'h0, 0, 1, 2'd0, 2, 1);
      cycle(0, 4'h0, 0, 1, 2'd0, 2, 0);
      check_eq("req_after_cr", 32'(read_cache), 32'd1);

      // Unsupported snoop opcode
      cycle(1, 4'b0011, 0, 0, 2'd0, 0, 0);
      check_eq("bad_snp_crresp", 32'(crresp), 32'b00010);
      check_eq("bad_snp_st", 32'(state_dbg[2:0]), 32'd1);
      cycle(0, 4'h0, 0, 0, 2'd0, 0, 1);

      // Reset while a response is pending
      cycle(1, 4'b0000, 2, 0, 2'd0, 0, 0);
      check_eq("pre_rst_crvalid", 32'(crvalid), 32'd1);
      do_reset();

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 249) == 0) do_reset();
         else cycle(1'($urandom_range(0, 2) == 0), snp_tab[$urandom_range(0, 7)],
                    IDX_W'($urandom), 1'($urandom), 2'($urandom), IDX_W'($urandom),
                    1'($urandom_range(0, 2) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
